inference_scorer: RTL

Downstream consumer of the final inference layer: takes the last layer's post-ReLU output vector and the one-hot label, then finds the winning class with a sequential argmax scan. It keeps running hit/total statistics and computes integer percentage accuracy with a serial divider. It drives `obtained_output`, `accuracy`, the `begin_next` pulse that advances the input loader, and end-of-run completion.

---
 rtl/scorer_pkg.sv | 18 +
 rtl/seq_divider.sv | 58 +++++
 rtl/inference_scorer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/scorer_pkg.sv
// Shared types and width helpers for the inference scorer.
// Holds the controller state encoding.
package scorer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMPARE,
    ST_DIVIDE,
    ST_REPORT,
    ST_DONE
  } scorer_state_t;

  function automatic int width_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// done is high in the cycle whose closing edge writes the last bit.
module seq_divider
  import scorer_pkg::*;
#(
  parameter int div_w = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [div_w-1:0] dividend,
  input  logic [div_w-1:0] divisor,
  output logic [div_w-1:0] quotient,
  output logic             done
);

  localparam int cw = $clog2(div_w + 1);

  logic [div_w-1:0] r_rem;
  logic [div_w-1:0] r_q;
  logic [div_w-1:0] r_dvs;
  logic [cw-1:0]    r_cnt;
  logic             r_busy;

  logic [div_w:0]   w_sh;
  logic [div_w:0]   w_diff;
  logic             w_ge;

  // Partial remainder stays below the divisor, so the borrow bit is the test.
  assign w_sh   = {r_rem, r_q[div_w-1]};
  assign w_diff = w_sh - {1'b0, r_dvs};
  assign w_ge   = ~w_diff[div_w];

  assign done     = r_busy && (r_cnt == cw'(div_w - 1));
  assign quotient = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_rem  <= '0;
      r_q    <= dividend;
      r_dvs  <= divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_diff[div_w-1:0] : w_sh[div_w-1:0];
      r_q    <= {r_q[div_w-2:0], w_ge};
      r_cnt  <= r_cnt + cw'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/inference_scorer.sv
// Scores final-layer vectors: argmax scan, hit/total tally,
// serial percentage accuracy and run completion.
module inference_scorer
  import scorer_pkg::*;
#(
  parameter int  num_classes = 10,
  parameter int  datawidth   = 8,
  parameter int  max_inputs  = 200,
  localparam int cnt_w       = width_of(max_inputs),
  localparam int div_w       = width_of(max_inputs * 100)
) (
  input  logic                           clk,
  input  logic                           rst_overall,
  input  logic                           rst_vals,
  input  logic                           layer_valid,
  output logic                           layer_ready,
  input  logic [num_classes*datawidth-1:0] layer_out,
  input  logic [num_classes-1:0]         expected_output,
  output logic [num_classes-1:0]         obtained_output,
  output logic [8:0]                     accuracy,
  output logic [cnt_w-1:0]               count,
  output logic [cnt_w-1:0]               correct_count,
  output logic                           begin_next,
  output logic                           all_done
);

  localparam int iw = (num_classes > 1) ? $clog2(num_classes) : 1;

  scorer_state_t                   r_state;
  logic [iw-1:0]                   r_idx;
  logic [num_classes*datawidth-1:0] r_vec;
  logic [num_classes-1:0]          r_label;
  logic [datawidth-1:0]            r_max;
  logic [iw-1:0]                   r_best;
  logic [num_classes-1:0]          r_obt;
  logic [8:0]                      r_acc;
  logic [cnt_w-1:0]                r_count;
  logic [cnt_w-1:0]                r_correct;
  logic                            r_bnext;
  logic                            r_done;

  logic [datawidth-1:0]   w_elem;
  logic [num_classes-1:0] w_onehot;
  logic                   w_hit;
  logic [cnt_w-1:0]       w_cnt_nx;
  logic [cnt_w-1:0]       w_cor_nx;
  logic [div_w-1:0]       w_dividend;
  logic [div_w-1:0]       w_divisor;
  logic [div_w-1:0]       w_quot;
  logic                   w_start;
  logic                   w_div_done;

  always_comb begin
    w_elem   = '0;
    w_onehot = '0;
    for (int i = 0; i < num_classes; i++) begin
      if (r_idx == iw'(i))  w_elem      = r_vec[i*datawidth +: datawidth];
      if (r_best == iw'(i)) w_onehot[i] = 1'b1;
    end
  end

  // A malformed label never equals a one-hot, so it always scores a miss.
  assign w_hit      = (r_label == w_onehot);
  assign w_cnt_nx   = r_count + cnt_w'(1);
  assign w_cor_nx   = r_correct + cnt_w'(w_hit);
  assign w_dividend = div_w'(w_cor_nx) * div_w'(100);
  assign w_divisor  = div_w'(w_cnt_nx);
  assign w_start    = (r_state == ST_COMPARE) && !rst_vals;

  seq_divider #(
    .div_w(div_w)
  ) u_div (
    .clk      (clk),
    .rst      (rst_overall),
    .start    (w_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .quotient (w_quot),
    .done     (w_div_done)
  );

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_vec     <= '0;
      r_label   <= '0;
      r_max     <= '0;
      r_best    <= '0;
      r_obt     <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_correct <= '0;
      r_bnext   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_bnext <= 1'b0;
      if (rst_vals) begin
        r_state   <= ST_IDLE;
        r_obt     <= '0;
        r_acc     <= '0;
        r_count   <= '0;
        r_correct <= '0;
        r_done    <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (layer_valid) begin
              r_vec   <= layer_out;
              r_label <= expected_output;
              r_idx   <= '0;
              r_max   <= '0;
              r_best  <= '0;
              r_state <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            // Strict compare keeps the lowest index on ties.
            if (w_elem > r_max) begin
              r_max  <= w_elem;
              r_best <= r_idx;
            end
            if (r_idx == iw'(num_classes - 1)) r_state <= ST_COMPARE;
            else r_idx <= r_idx + iw'(1);
          end
          ST_COMPARE: begin
            r_obt     <= w_onehot;
            r_count   <= w_cnt_nx;
            r_correct <= w_cor_nx;
            r_state   <= ST_DIVIDE;
          end
          ST_DIVIDE: begin
            if (w_div_done) r_state <= ST_REPORT;
          end
          ST_REPORT: begin
            r_acc   <= 9'(w_quot);
            r_bnext <= 1'b1;
            if (r_count == cnt_w'(max_inputs)) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_DONE: r_state <= ST_DONE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign layer_ready     = (r_state == ST_IDLE);
  assign obtained_output = r_obt;
  assign accuracy        = r_acc;
  assign count           = r_count;
  assign correct_count   = r_correct;
  assign begin_next      = r_bnext;
  assign all_done        = r_done;

endmodule
